// File: rtl/ctrl_seq_if.sv
// Control bundle between the ctrl_seq sequencer and its instruction ROM,
// program counter, reg_file, ALU and data_memory.
interface ctrl_seq_if #(
  parameter int RAW = 3,
  parameter int OPW = 3
);
  localparam int IW = 3 + 2 * RAW;

  logic           Start;
  logic [IW-1:0]  Instruction;
  logic           PCInit;
  logic           PCEn;
  logic           JumpEqual;
  logic           JumpNotEqual;
  logic           RegWrEn;
  logic           MemWrEn;
  logic           MemRdEn;
  logic [1:0]     WriteSource;
  logic [RAW-1:0] RdAddrA;
  logic [RAW-1:0] RdAddrB;
  logic [RAW-1:0] WriteRegAddr;
  logic [OPW-1:0] ALUOp;
  logic           Busy;
  logic           Ack;

  // Sequencer side: consumes Start/Instruction, drives every enable.
  modport master (
    input  Start, Instruction,
    output PCInit, PCEn, JumpEqual, JumpNotEqual, RegWrEn, MemWrEn, MemRdEn,
    output WriteSource, RdAddrA, RdAddrB, WriteRegAddr, ALUOp, Busy, Ack
  );

  // Datapath / environment side.
  modport slave (
    output Start, Instruction,
    input  PCInit, PCEn, JumpEqual, JumpNotEqual, RegWrEn, MemWrEn, MemRdEn,
    input  WriteSource, RdAddrA, RdAddrB, WriteRegAddr, ALUOp, Busy, Ack
  );
endinterface

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH -> EXEC -> (MEMWAIT) -> (WB) and drives all datapath enables.
// Every output is a register updated together with the state, so the value
// seen in a cycle is the value belonging to the state occupied in that cycle.
// PCInit accompanies the first FETCH after Start; PCEn accompanies the last
// busy cycle of each instruction, so each instruction boundary sees exactly one.
module ctrl_seq #(
  parameter int RAW     = 3,
  parameter int MEM_LAT = 2,
  parameter int OPW     = 3
) (
  input logic        Clk,
  input logic        Reset_n,
  ctrl_seq_if.master bus
);
  localparam int IW = 3 + 2 * RAW;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  // ALU operation encodings
  localparam logic [OPW-1:0] kLSH = OPW'(32'd0);
  localparam logic [OPW-1:0] kRSH = OPW'(32'd1);
  localparam logic [OPW-1:0] kADD = OPW'(32'd2);
  localparam logic [OPW-1:0] kORR = OPW'(32'd3);

  // Opcodes (IR[IW-1:IW-3])
  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_LDR = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;
  localparam logic [2:0] OP_BR  = 3'b101;
  localparam logic [2:0] OP_ORR = 3'b110;
  localparam logic [2:0] OP_LUT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_MEMWAIT = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  typedef struct packed {
    logic           pc_init;
    logic           pc_en;
    logic           jeq;
    logic           jne;
    logic           reg_wr;
    logic           mem_wr;
    logic           mem_rd;
    logic [1:0]     wsrc;
    logic [RAW-1:0] rda;
    logic [RAW-1:0] rdb;
    logic [RAW-1:0] wa;
    logic [OPW-1:0] alu_op;
    logic           busy;
    logic           ack;
  } outs_t;

  state_t         state_r;
  logic [IW-1:0]  ir_r;
  logic [CW-1:0]  cnt_r;
  outs_t          out_r;

  function automatic logic is_halt(input logic [IW-1:0] ir);
    return (ir == {IW{1'b1}});
  endfunction

  function automatic logic is_ldr(input logic [IW-1:0] ir);
    return (ir[IW-1 -: 3] == OP_LDR);
  endfunction

  // FETCH: only Busy, plus PCInit on the FETCH that follows a Start.
  function automatic outs_t fetch_outs(input logic init);
    outs_t o;
    o         = '0;
    o.busy    = 1'b1;
    o.pc_init = init;
    return o;
  endfunction

  // HALT: everything quiet except Ack.
  function automatic outs_t halt_outs();
    outs_t o;
    o     = '0;
    o.ack = 1'b1;
    return o;
  endfunction

  // Load wait / writeback: addresses and source held, enables only on WB.
  function automatic outs_t load_outs(input logic [IW-1:0] ir, input logic wb);
    outs_t o;
    o        = '0;
    o.busy   = 1'b1;
    o.wsrc   = 2'b01;
    o.wa     = ir[2*RAW-1 -: RAW];
    o.rdb    = ir[RAW-1:0];
    o.reg_wr = wb;
    o.pc_en  = wb;
    return o;
  endfunction

  // EXEC decode of an instruction word.
  function automatic outs_t exec_outs(input logic [IW-1:0] ir);
    outs_t          o;
    logic [2:0]     op;
    logic [RAW-1:0] a;
    logic [RAW-1:0] b;
    o      = '0;
    o.busy = 1'b1;
    op     = ir[IW-1 -: 3];
    a      = ir[2*RAW-1 -: RAW];
    b      = ir[RAW-1:0];
    case (op)
      OP_LSL: begin
        o.wa = a; o.rdb = b; o.alu_op = kLSH; o.reg_wr = 1'b1; o.pc_en = 1'b1;
      end
      OP_LSR: begin
        o.wa = a; o.rdb = b; o.alu_op = kRSH; o.reg_wr = 1'b1; o.pc_en = 1'b1;
      end
      OP_ADD: begin
        o.wa = a; o.rda = a; o.rdb = b; o.alu_op = kADD;
        o.reg_wr = 1'b1; o.pc_en = 1'b1;
      end
      OP_LDR: begin
        o.wa = a; o.rdb = b; o.wsrc = 2'b01; o.mem_rd = 1'b1;
      end
      OP_STR: begin
        o.rda = a; o.rdb = b; o.mem_wr = 1'b1; o.pc_en = 1'b1;
      end
      OP_BR: begin
        o.jeq = ~a[RAW-1]; o.jne = a[RAW-1]; o.pc_en = 1'b1;
      end
      OP_ORR: begin
        o.wa = a; o.rda = a; o.rdb = b; o.alu_op = kORR;
        o.reg_wr = 1'b1; o.pc_en = 1'b1;
      end
      OP_LUT: begin
        if (is_halt(ir)) begin
          o.busy = 1'b1;
        end else begin
          o.wa = a; o.wsrc = 2'b10; o.reg_wr = 1'b1; o.pc_en = 1'b1;
        end
      end
      default: begin
        o.busy = 1'b1;
      end
    endcase
    return o;
  endfunction

  // Sequencer: next state, IR capture, load-wait counter and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= S_IDLE;
      ir_r    <= '0;
      cnt_r   <= '0;
      out_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.Start) begin
            state_r <= S_FETCH;
            out_r   <= fetch_outs(1'b1);
          end else begin
            state_r <= S_IDLE;
            out_r   <= '0;
          end
        end
        S_HALT: begin
          if (bus.Start) begin
            state_r <= S_FETCH;
            out_r   <= fetch_outs(1'b1);
          end else begin
            state_r <= S_HALT;
            out_r   <= halt_outs();
          end
        end
        S_FETCH: begin
          state_r <= S_EXEC;
          ir_r    <= bus.Instruction;
          out_r   <= exec_outs(bus.Instruction);
        end
        S_EXEC: begin
          if (is_halt(ir_r)) begin
            state_r <= S_HALT;
            out_r   <= halt_outs();
          end else if (is_ldr(ir_r)) begin
            if (MEM_LAT == 1) begin
              state_r <= S_WB;
              out_r   <= load_outs(ir_r, 1'b1);
            end else begin
              state_r <= S_MEMWAIT;
              cnt_r   <= CW'(MEM_LAT - 1);
              out_r   <= load_outs(ir_r, 1'b0);
            end
          end else begin
            state_r <= S_FETCH;
            out_r   <= fetch_outs(1'b0);
          end
        end
        S_MEMWAIT: begin
          if (cnt_r <= CW'(1)) begin
            state_r <= S_WB;
            cnt_r   <= '0;
            out_r   <= load_outs(ir_r, 1'b1);
          end else begin
            state_r <= S_MEMWAIT;
            cnt_r   <= cnt_r - CW'(1);
            out_r   <= load_outs(ir_r, 1'b0);
          end
        end
        S_WB: begin
          state_r <= S_FETCH;
          out_r   <= fetch_outs(1'b0);
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= '0;
          out_r   <= '0;
        end
      endcase
    end
  end

  assign bus.PCInit       = out_r.pc_init;
  assign bus.PCEn         = out_r.pc_en;
  assign bus.JumpEqual    = out_r.jeq;
  assign bus.JumpNotEqual = out_r.jne;
  assign bus.RegWrEn      = out_r.reg_wr;
  assign bus.MemWrEn      = out_r.mem_wr;
  assign bus.MemRdEn      = out_r.mem_rd;
  assign bus.WriteSource  = out_r.wsrc;
  assign bus.RdAddrA      = out_r.rda;
  assign bus.RdAddrB      = out_r.rdb;
  assign bus.WriteRegAddr = out_r.wa;
  assign bus.ALUOp        = out_r.alu_op;
  assign bus.Busy         = out_r.busy;
  assign bus.Ack          = out_r.ack;
endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: four instances (RAW/MEM_LAT = 3/1, 3/2, 3/4, 4/3)
// exercised one after another with directed and random instructions; each
// cycle's outputs are compared against a trace derived from the decode table.
module tb_ctrl_seq;
  localparam int NI = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] start = '0;
  logic [10:0]   instr [NI];
  logic [25:0]   obs   [NI];
  int            checks = 0;
  int            errors = 0;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int RAWG = (g == 3) ? 4 : 3;
    localparam int LATG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 3;
    localparam int IWG  = 3 + 2 * RAWG;
    ctrl_seq_if #(.RAW(RAWG), .OPW(3)) bus ();
    ctrl_seq #(.RAW(RAWG), .MEM_LAT(LATG), .OPW(3)) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
    );
    assign bus.Start       = start[g];
    assign bus.Instruction = instr[g][IWG-1:0];
    assign obs[g] = {bus.PCInit, bus.PCEn, bus.JumpEqual, bus.JumpNotEqual,
                     bus.RegWrEn, bus.MemWrEn, bus.MemRdEn, bus.WriteSource,
                     4'(bus.RdAddrA), 4'(bus.RdAddrB), 4'(bus.WriteRegAddr),
                     bus.ALUOp, bus.Busy, bus.Ack};
  end

  function automatic int raw_of(input int k);
    return (k == 3) ? 4 : 3;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 3;
  endfunction

  function automatic logic [25:0] mk(input logic pi, pe, je, jn, rw, mw, mr,
                                     input int ws, ra, rb, wa, alu,
                                     input logic bz, ak);
    return {pi, pe, je, jn, rw, mw, mr, 2'(ws), 4'(ra), 4'(rb), 4'(wa),
            3'(alu), bz, ak};
  endfunction

  function automatic logic [25:0] fetch_exp(input logic pi);
    return mk(pi, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  function automatic logic [25:0] halt_exp();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic logic [25:0] ld_exp(input int raw, input int w, input logic wb);
    int mask;
    mask = (1 << raw) - 1;
    return mk(0, wb, 0, 0, wb, 0, 0, 1, 0, w & mask, (w >> raw) & mask, 0, 1, 0);
  endfunction

  // Expected EXEC-cycle outputs, each field derived separately from the op table.
  function automatic logic [25:0] exec_exp(input int raw, input int w);
    int   mask, op, a, b, ws, alu, ra, rb, wa;
    logic hlt, rw, pe, je, jn;
    mask = (1 << raw) - 1;
    op   = (w >> (2 * raw)) & 7;
    a    = (w >> raw) & mask;
    b    = w & mask;
    hlt  = (w == (1 << (3 + 2 * raw)) - 1);
    rw   = (op == 0 || op == 1 || op == 2 || op == 6 || (op == 7 && !hlt));
    wa   = (rw || op == 3) ? a : 0;
    ra   = (op == 2 || op == 4 || op == 6) ? a : 0;
    rb   = (op <= 4 || op == 6) ? b : 0;
    alu  = (op == 1) ? 1 : (op == 2) ? 2 : (op == 6) ? 3 : 0;
    ws   = (op == 3) ? 1 : (op == 7 && !hlt) ? 2 : 0;
    pe   = (op != 3) && !hlt;
    je   = (op == 5) && (((a >> (raw - 1)) & 1) == 0);
    jn   = (op == 5) && (((a >> (raw - 1)) & 1) == 1);
    return mk(0, pe, je, jn, rw, op == 4, op == 3, ws, ra, rb, wa, alu, 1, 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [25:0] got,
                     input logic [25:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%h expected=%h", tag, k, got, exp);
    end
  endtask

  // One instruction starting from a FETCH cycle; ends in the next FETCH.
  task automatic do_instr(input int k, input int w, input int hold);
    int   raw, op;
    logic hlt;
    raw = raw_of(k);
    op  = (w >> (2 * raw)) & 7;
    hlt = (w == (1 << (3 + 2 * raw)) - 1);
    instr[k] = 11'(w);
    start[k] = 1'($urandom_range(0, 1));
    step();
    chk("exec", k, obs[k], exec_exp(raw, w));
    if (hlt) begin
      start[k] = (hold == 0);
      step();
      chk("halt", k, obs[k], halt_exp());
      for (int i = 0; i < hold; i++) begin
        step();
        chk("halt_hold", k, obs[k], halt_exp());
      end
      start[k] = 1'b1;
      step();
      chk("restart", k, obs[k], fetch_exp(1'b1));
      start[k] = 1'b0;
    end else if (op == 3) begin
      for (int i = 1; i < lat_of(k); i++) begin
        start[k] = 1'($urandom_range(0, 1));
        step();
        chk("memwait", k, obs[k], ld_exp(raw, w, 1'b0));
      end
      start[k] = 1'($urandom_range(0, 1));
      step();
      chk("wb", k, obs[k], ld_exp(raw, w, 1'b1));
      start[k] = 1'($urandom_range(0, 1));
      step();
      chk("fetch_ld", k, obs[k], fetch_exp(1'b0));
    end else begin
      start[k] = 1'($urandom_range(0, 1));
      step();
      chk("fetch", k, obs[k], fetch_exp(1'b0));
    end
  endtask

  task automatic run_prog(input int k);
    int raw, iw, hw;
    int d[6];
    raw = raw_of(k);
    iw  = 3 + 2 * raw;
    hw  = (1 << iw) - 1;
    if (raw == 4) d = '{32'h023, 32'h314, 32'h456, 32'h521, 32'h5A1, 32'h732};
    else          d = '{32'h013, 32'h0CC, 32'h12E, 32'h151, 32'h171, 32'h1DA};
    start[k] = 1'b1;
    step();
    chk("start", k, obs[k], fetch_exp(1'b1));
    start[k] = 1'b0;
    for (int i = 0; i < 6; i++) do_instr(k, d[i], 0);
    for (int i = 0; i < 12; i++) do_instr(k, int'($urandom_range(0, hw)), 1);
    do_instr(k, hw, 10);
    do_instr(k, d[0], 0);
    do_instr(k, hw, 0);
  endtask

  // Async reset in the middle of a load wait on the MEM_LAT=3 instance.
  task automatic reset_midload();
    start[3] = 1'b1;
    step();
    chk("rl_start", 3, obs[3], fetch_exp(1'b1));
    start[3] = 1'b0;
    instr[3] = 11'h314;
    step();
    chk("rl_exec", 3, obs[3], exec_exp(4, 32'h314));
    step();
    chk("rl_memwait", 3, obs[3], ld_exp(4, 32'h314, 1'b0));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 3, obs[3], 26'd0);
    step();
    chk("rst_hold", 3, obs[3], 26'd0);
    rst_n = 1'b1;
    step();
    chk("rst_idle", 3, obs[3], 26'd0);
    step();
    chk("rst_idle2", 3, obs[3], 26'd0);
  endtask

  // Bound on total run time.
  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Directed sequence: reset, per-instance programs, mid-load reset.
  initial begin
    for (int i = 0; i < NI; i++) instr[i] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk("reset", i, obs[i], 26'd0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NI; i++) chk("idle", i, obs[i], 26'd0);
    run_prog(0);
    run_prog(1);
    run_prog(2);
    reset_midload();
    run_prog(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
